// File: rtl/state_ex_if.sv
// Execute-stage bundle: decode-side operands in, memory-side results out, busy feedback both ways.
// Latency: none (wires only).
// Backpressure: mem_busy stalls the execute stage, fb_ex stalls decode.
interface state_ex_if;
    // decode -> execute
    logic        complete_pre;
    logic [31:0] PC_input;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        funct7_0;
    logic [8:0]  op_class;
    logic [4:0]  RF_waddr_in;
    // memory -> execute
    logic        mem_busy;
    // execute -> memory / decode / fetch
    logic        complete_this;
    logic [31:0] PC_output;
    logic [4:0]  RF_waddr_out;
    logic [8:0]  mem_info_out;
    logic [31:0] Write_data_out;
    logic [31:0] mem_address_out;
    logic        br_valid;
    logic [31:0] br_target;
    logic        fb_ex;

    modport master (
        output complete_pre, PC_input, rs1_data, rs2_data, imm, funct3, funct7_5,
               funct7_0, op_class, RF_waddr_in, mem_busy,
        input  complete_this, PC_output, RF_waddr_out, mem_info_out, Write_data_out,
               mem_address_out, br_valid, br_target, fb_ex
    );

    modport slave (
        input  complete_pre, PC_input, rs1_data, rs2_data, imm, funct3, funct7_5,
               funct7_0, op_class, RF_waddr_in, mem_busy,
        output complete_this, PC_output, RF_waddr_out, mem_info_out, Write_data_out,
               mem_address_out, br_valid, br_target, fb_ex
    );
endinterface

// File: rtl/state_ex.sv
// RV32 execute stage: ALU, branch resolve, store lane alignment, optional MUL (macro RV32_MUL_EN).
// Latency: accept at t -> complete_this at t+2 (MUL build: t+34 for MUL ops), plus mem_busy stall cycles.
// Backpressure: holds in EXE/MUL while mem_busy; fb_ex high while busy, complete_pre ignored outside INIT.
module state_ex (
    input  logic       clk,
    input  logic       rst,
    state_ex_if.slave  ex
);

`ifdef RV32_MUL_EN
    typedef enum logic [3:0] {
        INIT = 4'b0001,
        EXE  = 4'b0010,
        MUL  = 4'b0100,
        COM  = 4'b1000
    } state_t;
`else
    typedef enum logic [2:0] {
        INIT = 3'b001,
        EXE  = 3'b010,
        COM  = 3'b100
    } state_t;
`endif

    state_t state_q, state_d;

    // latched instruction
    logic [31:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [2:0]  f3_q;
    logic        f75_q, f70_q;
    logic [8:0]  op_q;
    logic [4:0]  waddr_q;

    // decoded op class, bit order {R, I_alu, load, store, branch, jal, jalr, lui, auipc}
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_mul;

    // datapath
    logic [31:0] op2, alu_res, sra_res, exe_res, addr, st_data, wb_value;
    logic [4:0]  shamt;
    logic [3:0]  strb;
    logic        br_cond, redirect;
    logic        load_en, commit_en;

    // registered outputs
    logic [31:0] pc_out_q, wdata_q, maddr_q, btgt_q;
    logic [4:0]  rf_waddr_q;
    logic [8:0]  mem_info_q;
    logic        redirect_q;

    assign is_r     = op_q[8];
    assign is_i     = op_q[7];
    assign is_ld    = op_q[6];
    assign is_st    = op_q[5];
    assign is_br    = op_q[4];
    assign is_jal   = op_q[3];
    assign is_jalr  = op_q[2];
    assign is_lui   = op_q[1];
    assign is_auipc = op_q[0];
    assign is_mul   = is_r & f70_q;

    assign load_en   = (state_q == INIT) && ex.complete_pre;
    assign commit_en = (state_d == COM) && (state_q != COM);

    // state register; reset abandons any in-flight op
    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

`ifdef RV32_MUL_EN
    // shift-add multiplier, one multiplier bit per MUL cycle
    logic [31:0] mcand_q, mplier_q, acc_q, acc_next, mul_prod;
    logic [5:0]  mul_cnt_q;
    logic        mul_last;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign mul_last = (mul_cnt_q >= 6'd31);
    // after the 32nd step the accumulator already holds the product
    assign mul_prod = (mul_cnt_q == 6'd32) ? acc_q : acc_next;

    // load operands while in EXE, iterate while in MUL until 32 steps done
    always_ff @(posedge clk) begin
        if (state_q == EXE) begin
            mcand_q   <= rs1_q;
            mplier_q  <= rs2_q;
            acc_q     <= 32'd0;
            mul_cnt_q <= 6'd0;
        end else if (state_q == MUL && mul_cnt_q != 6'd32) begin
            acc_q     <= acc_next;
            mcand_q   <= {mcand_q[30:0], 1'b0};
            mplier_q  <= {1'b0, mplier_q[31:1]};
            mul_cnt_q <= mul_cnt_q + 6'd1;
        end
    end
`endif

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: if (ex.complete_pre) state_d = EXE;
`ifdef RV32_MUL_EN
            EXE: begin
                if (is_mul)            state_d = MUL;
                else if (!ex.mem_busy) state_d = COM;
            end
            MUL: if (mul_last && !ex.mem_busy) state_d = COM;
`else
            EXE: if (!ex.mem_busy) state_d = COM;
`endif
            COM:     state_d = INIT;
            default: state_d = INIT;
        endcase
    end

    // capture the accepted instruction; later complete_pre pulses are ignored
    always_ff @(posedge clk) begin
        if (load_en) begin
            pc_q    <= ex.PC_input;
            rs1_q   <= ex.rs1_data;
            rs2_q   <= ex.rs2_data;
            imm_q   <= ex.imm;
            f3_q    <= ex.funct3;
            f75_q   <= ex.funct7_5;
            f70_q   <= ex.funct7_0;
            op_q    <= ex.op_class;
            waddr_q <= ex.RF_waddr_in;
        end
    end

    assign op2     = is_r ? rs2_q : imm_q;
    assign shamt   = op2[4:0];
    // kept on its own so the arithmetic shift stays signed
    assign sra_res = $signed(rs1_q) >>> shamt;
    assign addr    = rs1_q + imm_q;

    // ALU, subtract only for R-type with inst[30]
    always_comb begin
        alu_res = 32'd0;
        case (f3_q)
            3'd0: alu_res = (is_r && f75_q) ? (rs1_q - op2) : (rs1_q + op2);
            3'd1: alu_res = rs1_q << shamt;
            3'd2: alu_res = {31'd0, $signed(rs1_q) < $signed(op2)};
            3'd3: alu_res = {31'd0, rs1_q < op2};
            3'd4: alu_res = rs1_q ^ op2;
            3'd5: alu_res = f75_q ? sra_res : (rs1_q >> shamt);
            3'd6: alu_res = rs1_q | op2;
            3'd7: alu_res = rs1_q & op2;
            default: alu_res = 32'd0;
        endcase
    end

    // branch condition from funct3
    always_comb begin
        br_cond = 1'b0;
        case (f3_q)
            3'd0: br_cond = (rs1_q == rs2_q);
            3'd1: br_cond = (rs1_q != rs2_q);
            3'd4: br_cond = ($signed(rs1_q) <  $signed(rs2_q));
            3'd5: br_cond = ($signed(rs1_q) >= $signed(rs2_q));
            3'd6: br_cond = (rs1_q <  rs2_q);
            3'd7: br_cond = (rs1_q >= rs2_q);
            default: br_cond = 1'b0;
        endcase
    end

    assign redirect = (is_br & br_cond) | is_jal | is_jalr;

    // store byte strobes and lane-replicated store data
    always_comb begin
        strb    = 4'b0000;
        st_data = rs2_q;
        if (is_st) begin
            case (f3_q[1:0])
                2'd0: begin
                    strb    = 4'b0001 << addr[1:0];
                    st_data = {4{rs2_q[7:0]}};
                end
                2'd1: begin
                    strb    = 4'b0011 << {addr[1], 1'b0};
                    st_data = {2{rs2_q[15:0]}};
                end
                default: begin
                    strb    = 4'b1111;
                    st_data = rs2_q;
                end
            endcase
        end
    end

    // writeback value; loads carry the address, MUL without the multiplier yields 0
    always_comb begin
        exe_res = 32'd0;
        if (is_lui)                exe_res = imm_q;
        else if (is_auipc)         exe_res = pc_q + imm_q;
        else if (is_jal | is_jalr) exe_res = pc_q + 32'd4;
        else if (is_ld)            exe_res = addr;
        else if (is_mul)           exe_res = 32'd0;
        else if (is_r | is_i)      exe_res = alu_res;
    end

`ifdef RV32_MUL_EN
    assign wb_value = (state_q == MUL) ? mul_prod : (is_st ? st_data : exe_res);
`else
    assign wb_value = is_st ? st_data : exe_res;
`endif

    // control-type outputs, reset so the memory stage never sees stale writes
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_waddr_q <= 5'd0;
            mem_info_q <= 9'd0;
            redirect_q <= 1'b0;
        end else if (commit_en) begin
            rf_waddr_q <= (is_br | is_st) ? 5'd0 : waddr_q;
            mem_info_q <= {f3_q, is_st, is_ld, strb};
            redirect_q <= redirect;
        end
    end

    // data outputs, frozen from COM entry until the next commit
    always_ff @(posedge clk) begin
        if (commit_en) begin
            pc_out_q <= pc_q;
            wdata_q  <= wb_value;
            maddr_q  <= addr;
            btgt_q   <= is_jalr ? (addr & ~32'd1) : (pc_q + imm_q);
        end
    end

    assign ex.complete_this   = ~rst & (state_q == COM);
    assign ex.br_valid        = ~rst & (state_q == COM) & redirect_q;
    assign ex.fb_ex           = ~rst & (state_q != INIT);
    assign ex.PC_output       = pc_out_q;
    assign ex.RF_waddr_out    = rf_waddr_q;
    assign ex.mem_info_out    = mem_info_q;
    assign ex.Write_data_out  = wdata_q;
    assign ex.mem_address_out = maddr_q;
    assign ex.br_target       = btgt_q;

endmodule

// File: tb/tb_state_ex.sv
// Bench for state_ex: directed vector table plus hand sequences for stall, ignore, MUL and reset abort.
// Expected values are hand-computed constants; MUL latency/result follow RV32_MUL_EN.
// All DUT outputs are sampled 1 ns after the rising edge.
module tb_state_ex;
    logic clk = 1'b0;
    logic rst;
    state_ex_if bus();

    state_ex dut (.clk(clk), .rst(rst), .ex(bus));

    always #5 clk = ~clk;

    localparam logic [8:0] OP_R = 9'h100, OP_I = 9'h080, OP_LD = 9'h040, OP_ST = 9'h020,
                           OP_BR = 9'h010, OP_JAL = 9'h008, OP_JALR = 9'h004,
                           OP_LUI = 9'h002, OP_AUIPC = 9'h001;

    typedef struct {
        string       name;
        logic [8:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  wa;
        logic        chk_wd;
        logic [31:0] wd, addr;
        logic [8:0]  mi;
        logic        bv;
        logic [31:0] bt;
        logic [4:0]  rfo;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(string nm, logic [8:0] op, logic [2:0] f3, logic f75,
                                logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic [4:0] wa, logic chk_wd,
                                logic [31:0] wd, logic [31:0] addr, logic [8:0] mi,
                                logic bv, logic [31:0] bt, logic [4:0] rfo);
        vec_t v;
        v.name = nm; v.op = op; v.f3 = f3; v.f75 = f75; v.pc = pc; v.rs1 = rs1;
        v.rs2 = rs2; v.imm = imm; v.wa = wa; v.chk_wd = chk_wd; v.wd = wd;
        v.addr = addr; v.mi = mi; v.bv = bv; v.bt = bt; v.rfo = rfo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [8:0] op, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] wa);
        bus.complete_pre = 1'b1;
        bus.op_class = op; bus.funct3 = f3; bus.funct7_5 = f75; bus.funct7_0 = f70;
        bus.PC_input = pc; bus.rs1_data = rs1; bus.rs2_data = rs2; bus.imm = imm;
        bus.RF_waddr_in = wa;
        @(posedge clk); #1;
        bus.complete_pre = 1'b0;
    endtask

    // counts edges after acceptance until complete_this; a timeout is a failed comparison
    task automatic wait_done(input string nm, output int n);
        n = 0;
        while (bus.complete_this !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.complete_this !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no complete_this, expected it within 100 cycles", nm);
        end
    endtask

    initial begin
        int n;
        int spurious;
        vec_t v;

        vq.push_back(mk("add_wrap", OP_R, 3'd0, 1'b0, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd5,
                        1'b1, 32'h80000000, 32'h7FFFFFFF, 9'h000, 1'b0, 32'h0, 5'd5));
        vq.push_back(mk("sub", OP_R, 3'd0, 1'b1, 32'h0, 32'h5, 32'h7, 32'h0, 5'd3,
                        1'b1, 32'hFFFFFFFE, 32'h5, 9'h000, 1'b0, 32'h0, 5'd3));
        vq.push_back(mk("srai", OP_I, 3'd5, 1'b1, 32'h0, 32'h80000000, 32'h0, 32'h404, 5'd1,
                        1'b1, 32'hF8000000, 32'h80000404, 9'h140, 1'b0, 32'h0, 5'd1));
        vq.push_back(mk("sltu", OP_R, 3'd3, 1'b0, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 5'd2,
                        1'b1, 32'h1, 32'h1, 9'h0C0, 1'b0, 32'h0, 5'd2));
        vq.push_back(mk("slt", OP_R, 3'd2, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd2,
                        1'b1, 32'h1, 32'hFFFFFFFF, 9'h080, 1'b0, 32'h0, 5'd2));
        vq.push_back(mk("xori", OP_I, 3'd4, 1'b0, 32'h0, 32'hF0F0F0F0, 32'h0, 32'hFFFFFFFF, 5'd8,
                        1'b1, 32'h0F0F0F0F, 32'hF0F0F0EF, 9'h100, 1'b0, 32'h0, 5'd8));
        vq.push_back(mk("sb", OP_ST, 3'd0, 1'b0, 32'h0, 32'h1000, 32'h12345678, 32'h3, 5'd9,
                        1'b1, 32'h78787878, 32'h1003, 9'h028, 1'b0, 32'h0, 5'd0));
        vq.push_back(mk("sh", OP_ST, 3'd1, 1'b0, 32'h0, 32'h2000, 32'hAABBCCDD, 32'h2, 5'd9,
                        1'b1, 32'hCCDDCCDD, 32'h2002, 9'h06C, 1'b0, 32'h0, 5'd0));
        vq.push_back(mk("lw", OP_LD, 3'd2, 1'b0, 32'h0, 32'h3000, 32'h0, 32'hFFFFFFFC, 5'd7,
                        1'b0, 32'h0, 32'h2FFC, 9'h090, 1'b0, 32'h0, 5'd7));
        vq.push_back(mk("blt", OP_BR, 3'd4, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 5'd4,
                        1'b0, 32'h0, 32'hFFFFFFF7, 9'h100, 1'b1, 32'hF8, 5'd0));
        vq.push_back(mk("bltu", OP_BR, 3'd6, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 5'd4,
                        1'b0, 32'h0, 32'hFFFFFFF7, 9'h180, 1'b0, 32'h0, 5'd0));
        vq.push_back(mk("jal", OP_JAL, 3'd0, 1'b0, 32'h200, 32'h0, 32'h0, 32'h40, 5'd1,
                        1'b1, 32'h204, 32'h40, 9'h000, 1'b1, 32'h240, 5'd1));
        vq.push_back(mk("jalr", OP_JALR, 3'd0, 1'b0, 32'h300, 32'h1001, 32'h0, 32'h4, 5'd1,
                        1'b1, 32'h304, 32'h1005, 9'h000, 1'b1, 32'h1004, 5'd1));
        vq.push_back(mk("lui", OP_LUI, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hABCDE000, 5'd10,
                        1'b1, 32'hABCDE000, 32'hABCDE000, 9'h000, 1'b0, 32'h0, 5'd10));
        vq.push_back(mk("auipc", OP_AUIPC, 3'd0, 1'b0, 32'h1000, 32'h0, 32'h0, 32'h2000, 5'd11,
                        1'b1, 32'h3000, 32'h2000, 9'h000, 1'b0, 32'h0, 5'd11));
        vq.push_back(mk("beq", OP_BR, 3'd0, 1'b0, 32'h40, 32'h5, 32'h5, 32'h10, 5'd12,
                        1'b0, 32'h0, 32'h15, 9'h000, 1'b1, 32'h50, 5'd0));
        vq.push_back(mk("sw", OP_ST, 3'd2, 1'b0, 32'h0, 32'h10, 32'hDEADBEEF, 32'h4, 5'd13,
                        1'b1, 32'hDEADBEEF, 32'h14, 9'h0AF, 1'b0, 32'h0, 5'd0));

        // reset state
        rst = 1'b1;
        bus.complete_pre = 1'b0; bus.mem_busy = 1'b0;
        bus.op_class = 9'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.funct7_0 = 1'b0;
        bus.PC_input = 32'd0; bus.rs1_data = 32'd0; bus.rs2_data = 32'd0; bus.imm = 32'd0;
        bus.RF_waddr_in = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_complete_this", {31'd0, bus.complete_this}, 32'd0);
        chk("rst_br_valid", {31'd0, bus.br_valid}, 32'd0);
        chk("rst_rf_waddr", {27'd0, bus.RF_waddr_out}, 32'd0);
        chk("rst_mem_info", {23'd0, bus.mem_info_out}, 32'd0);
        chk("rst_fb_ex", {31'd0, bus.fb_ex}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_fb_ex", {31'd0, bus.fb_ex}, 32'd0);

        // vector table
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            issue(v.op, v.f3, v.f75, 1'b0, v.pc, v.rs1, v.rs2, v.imm, v.wa);
            chk({v.name, "_fb_ex"}, {31'd0, bus.fb_ex}, 32'd1);
            wait_done(v.name, n);
            chk({v.name, "_latency"}, 32'(n), 32'd1);
            if (v.chk_wd) chk({v.name, "_wdata"}, bus.Write_data_out, v.wd);
            chk({v.name, "_addr"}, bus.mem_address_out, v.addr);
            chk({v.name, "_mem_info"}, {23'd0, bus.mem_info_out}, {23'd0, v.mi});
            chk({v.name, "_br_valid"}, {31'd0, bus.br_valid}, {31'd0, v.bv});
            if (v.bv) chk({v.name, "_br_target"}, bus.br_target, v.bt);
            chk({v.name, "_rf_waddr"}, {27'd0, bus.RF_waddr_out}, {27'd0, v.rfo});
            chk({v.name, "_pc_out"}, bus.PC_output, v.pc);
            @(posedge clk); #1;
            chk({v.name, "_pulse_end"}, {30'd0, bus.complete_this, bus.br_valid}, 32'd0);
        end

        // outputs hold after completion while idle
        repeat (3) @(posedge clk);
        #1;
        chk("hold_wdata", bus.Write_data_out, 32'hDEADBEEF);
        chk("hold_addr", bus.mem_address_out, 32'h14);

        // memory stall with an ignored complete_pre while busy
        bus.mem_busy = 1'b1;
        issue(OP_R, 3'd0, 1'b0, 1'b0, 32'h500, 32'h1, 32'h2, 32'h0, 5'd6);
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_complete", {31'd0, bus.complete_this}, 32'd0);
            chk("stall_fb_ex", {31'd0, bus.fb_ex}, 32'd1);
            if (i == 1) begin
                bus.complete_pre = 1'b1;
                bus.rs1_data = 32'h100;
                bus.RF_waddr_in = 5'd31;
            end
            @(posedge clk); #1;
            bus.complete_pre = 1'b0;
        end
        bus.mem_busy = 1'b0;
        chk("stall_release_wait", {31'd0, bus.complete_this}, 32'd0);
        @(posedge clk); #1;
        chk("stall_complete", {31'd0, bus.complete_this}, 32'd1);
        chk("stall_wdata", bus.Write_data_out, 32'h3);
        chk("stall_rf_waddr", {27'd0, bus.RF_waddr_out}, 32'd6);
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.complete_this === 1'b1) spurious++;
        end
        chk("ignored_pre_no_op", 32'(spurious), 32'd0);
        chk("stall_idle_fb_ex", {31'd0, bus.fb_ex}, 32'd0);

        // MUL 0xFFFFFFFF * 3
        issue(OP_R, 3'd0, 1'b0, 1'b1, 32'h600, 32'hFFFFFFFF, 32'h3, 32'h0, 5'd14);
        wait_done("mul", n);
`ifdef RV32_MUL_EN
        chk("mul_latency", 32'(n), 32'd33);
        chk("mul_result", bus.Write_data_out, 32'hFFFFFFFD);
`else
        chk("mul_latency", 32'(n), 32'd1);
        chk("mul_result", bus.Write_data_out, 32'h0);
`endif
        chk("mul_rf_waddr", {27'd0, bus.RF_waddr_out}, 32'd14);
        @(posedge clk); #1;

        // reset in the middle of an operation
`ifdef RV32_MUL_EN
        issue(OP_R, 3'd0, 1'b0, 1'b1, 32'h700, 32'h7, 32'h9, 32'h0, 5'd15);
        repeat (10) @(posedge clk);
        #1;
`else
        bus.mem_busy = 1'b1;
        issue(OP_R, 3'd0, 1'b0, 1'b1, 32'h700, 32'h7, 32'h9, 32'h0, 5'd15);
        repeat (3) @(posedge clk);
        #1;
`endif
        chk("abort_busy_before", {31'd0, bus.fb_ex}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_fb_ex_in_rst", {31'd0, bus.fb_ex}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_busy = 1'b0;
        #1;
        chk("abort_init_fb_ex", {31'd0, bus.fb_ex}, 32'd0);
        chk("abort_rf_waddr", {27'd0, bus.RF_waddr_out}, 32'd0);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.complete_this === 1'b1) spurious++;
        end
        chk("abort_no_complete", 32'(spurious), 32'd0);
        issue(OP_R, 3'd0, 1'b0, 1'b0, 32'h800, 32'd10, 32'd20, 32'h0, 5'd16);
        wait_done("post_abort", n);
        chk("post_abort_latency", 32'(n), 32'd1);
        chk("post_abort_wdata", bus.Write_data_out, 32'd30);
        chk("post_abort_rf_waddr", {27'd0, bus.RF_waddr_out}, 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
